// File: rtl/hand_centroid_tracker.sv
// Per-frame hand locator: accumulates skin-pixel coordinate sums over a frame,
// then divides by the pixel count serially and publishes one centroid per frame.
module hand_centroid_tracker #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int MIN_PIXELS = 16,
    parameter int SUM_W      = 28,
    parameter int CNT_W      = 19
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iDVAL,
    input  logic [9:0] iX,
    input  logic [9:0] iY,
    input  logic       iSkin,
    input  logic       iFrame_End,
    output logic [9:0] oFT_X,
    output logic [9:0] oFT_Y,
    output logic       oDVAL,
    output logic       oFrame_En,
    output logic       oOverrun
);

    localparam logic [1:0] ACCUM   = 2'd0;
    localparam logic [1:0] DIVIDE  = 2'd1;
    localparam logic [1:0] PUBLISH = 2'd2;
    localparam int         BC_W    = $clog2(SUM_W + 1);

    logic [1:0]       state;
    logic [SUM_W-1:0] sumX, sumY;
    logic [CNT_W-1:0] count;
    logic [SUM_W-1:0] quoX, quoY;
    logic [CNT_W-1:0] remX, remY, divisor;
    logic [BC_W-1:0]  bitCnt;

    logic             pixHit;
    logic [SUM_W-1:0] nextSumX, nextSumY;
    logic [CNT_W-1:0] nextCount;
    logic [SUM_W+CNT_W-1:0] stepX, stepY;

    // One restoring-division step: the quotient shifts in through the dividend
    // register, so after SUM_W steps it holds the full quotient.
    function automatic logic [SUM_W+CNT_W-1:0] divStep(
        input logic [SUM_W-1:0] quo,
        input logic [CNT_W-1:0] rem,
        input logic [CNT_W-1:0] dsr
    );
        logic [CNT_W:0] trial;
        logic [CNT_W:0] diff;
        trial = {rem, quo[SUM_W-1]};
        diff  = trial - {1'b0, dsr};
        if (trial >= {1'b0, dsr})
            return {quo[SUM_W-2:0], 1'b1, diff[CNT_W-1:0]};
        else
            return {quo[SUM_W-2:0], 1'b0, trial[CNT_W-1:0]};
    endfunction

    assign pixHit = iDVAL && iSkin && (32'(iX) < WIDTH) && (32'(iY) < HEIGHT);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        nextSumX  = sumX;
        nextSumY  = sumY;
        nextCount = count;
        if (pixHit) begin
            nextSumX  = sumX + SUM_W'(iX);
            nextSumY  = sumY + SUM_W'(iY);
            nextCount = count + CNT_W'(1);
        end
    end

    assign stepX = divStep(quoX, remX, divisor);
    assign stepY = divStep(quoY, remY, divisor);

    // A pixel coincident with iFrame_End belongs to the ending frame, so the
    // accumulators always restart from zero.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sumX  <= '0;
            sumY  <= '0;
            count <= '0;
        end else if (iFrame_End) begin
            sumX  <= '0;
            sumY  <= '0;
            count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            sumX  <= nextSumX;
            sumY  <= nextSumY;
            count <= nextCount;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= ACCUM;
            quoX      <= '0;
            quoY      <= '0;
            remX      <= '0;
            remY      <= '0;
            divisor   <= '0;
            bitCnt    <= '0;
            oFT_X     <= '0;
            oFT_Y     <= '0;
            oDVAL     <= 1'b0;
            oFrame_En <= 1'b0;
            oOverrun  <= 1'b0;
        end else begin
            oFrame_En <= 1'b0;
            oOverrun  <= iFrame_End && (state != ACCUM);
            case (state)
                ACCUM: begin
                    if (iFrame_End) begin
                        quoX    <= nextSumX;
                        quoY    <= nextSumY;
                        divisor <= nextCount;
                        remX    <= '0;
                        remY    <= '0;
                        bitCnt  <= '0;
                        state   <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    {quoX, remX} <= stepX;
                    {quoY, remY} <= stepY;
                    bitCnt       <= bitCnt + BC_W'(1);
                    if (bitCnt == BC_W'(SUM_W - 1))
                        state <= PUBLISH;
                end
                PUBLISH: begin
                    oFrame_En <= 1'b1;
                    // Too few pixels (including none): keep the last position, drop valid.
                    if (32'(divisor) >= MIN_PIXELS) begin
                        oFT_X <= quoX[9:0];
                        oFT_Y <= quoY[9:0];
                        oDVAL <= 1'b1;
                    end else begin
                        oDVAL <= 1'b0;
                    end
                    state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_hand_centroid_tracker.sv
// Directed bench for hand_centroid_tracker: latency, centroid values, small/empty
// frames, coincident pixel, overrun, back-to-back frames and reset mid-divide.
module tb_hand_centroid_tracker;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       iDVAL = 1'b0;
    logic [9:0] iX = '0;
    logic [9:0] iY = '0;
    logic       iSkin = 1'b0;
    logic       iFrame_End = 1'b0;
    logic [9:0] oFT_X, oFT_Y;
    logic       oDVAL, oFrame_En, oOverrun;

    int vectors = 0;
    int miscompares = 0;

    hand_centroid_tracker dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iDVAL(iDVAL), .iX(iX), .iY(iY),
        .iSkin(iSkin), .iFrame_End(iFrame_End), .oFT_X(oFT_X), .oFT_Y(oFT_Y),
        .oDVAL(oDVAL), .oFrame_En(oFrame_En), .oOverrun(oOverrun)
    );

    always #5 iCLK = ~iCLK;

    // Apply one cycle of inputs across a rising edge; returns 1 ns after the edge.
    task automatic drive(input int x, input int y, input logic dv, input logic sk, input logic fe);
        iDVAL = dv; iX = 10'(x); iY = 10'(y); iSkin = sk; iFrame_End = fe;
        @(posedge iCLK); #1;
        iDVAL = 1'b0; iSkin = 1'b0; iFrame_End = 1'b0;
    endtask

    task automatic pixels(input int n, input int x, input int y, input logic sk);
        for (int i = 0; i < n; i++) drive(x, y, 1'b1, sk, 1'b0);
    endtask

    // Edges from the frame-end edge to the oFrame_En cycle; -1 if none within 60.
    task automatic wait_result(output int lat);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge iCLK); #1;
            if (oFrame_En) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic expect_result(input string name, input int lat, input int ex, input int ey, input logic edv);
        vectors++;
        if (lat !== 29) begin miscompares++; $display("FAIL %s_latency: got %0d expected 29", name, lat); end
        vectors++;
        if (oDVAL !== edv) begin miscompares++; $display("FAIL %s_dval: got %b expected %b", name, oDVAL, edv); end
        vectors++;
        if (oFT_X !== 10'(ex)) begin miscompares++; $display("FAIL %s_x: got %0d expected %0d", name, oFT_X, ex); end
        vectors++;
        if (oFT_Y !== 10'(ey)) begin miscompares++; $display("FAIL %s_y: got %0d expected %0d", name, oFT_Y, ey); end
    endtask

    task automatic test_reset;
        iRST_N = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        vectors++;
        if ({oFT_X, oFT_Y, oDVAL, oFrame_En, oOverrun} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got x=%0d y=%0d dval=%b fen=%b ovr=%b expected all 0",
                     oFT_X, oFT_Y, oDVAL, oFrame_En, oOverrun);
        end
        iRST_N = 1'b1;
        @(posedge iCLK); #1;
    endtask

    task automatic test_hand;
        int lat;
        for (int i = 0; i < 16; i++) drive(100 + i, 200, 1'b1, 1'b1, 1'b0);
        drive(0, 0, 1'b0, 1'b0, 1'b1);
        wait_result(lat);
        expect_result("hand", lat, 107, 200, 1'b1);
        @(posedge iCLK); #1;
        vectors++;
        if (oFrame_En !== 1'b0) begin miscompares++; $display("FAIL hand_pulse_width: got %b expected 0", oFrame_En); end
    endtask

    task automatic test_small_frame;
        int lat;
        pixels(15, 300, 300, 1'b1);
        drive(0, 0, 1'b0, 1'b0, 1'b1);
        wait_result(lat);
        expect_result("small", lat, 107, 200, 1'b0);
    endtask

    task automatic test_empty_frame;
        int lat;
        pixels(20, 10, 10, 1'b0);
        pixels(4, 700, 5, 1'b1);
        drive(0, 0, 1'b0, 1'b0, 1'b1);
        wait_result(lat);
        expect_result("empty", lat, 107, 200, 1'b0);
    endtask

    task automatic test_coincident;
        int lat;
        pixels(15, 639, 479, 1'b1);
        drive(639, 479, 1'b1, 1'b1, 1'b1);
        wait_result(lat);
        expect_result("coincident", lat, 639, 479, 1'b1);
    endtask

    task automatic test_overrun;
        int lat;
        int pulses;
        int at;
        logic [9:0] cx, cy;
        logic cdv;
        pulses = 0; at = -1; cx = '0; cy = '0; cdv = 1'b0;
        pixels(16, 20, 30, 1'b1);
        drive(0, 0, 1'b0, 1'b0, 1'b1);        // edge T
        pixels(5, 400, 400, 1'b1);            // T+1..T+5, discarded later
        repeat (4) drive(0, 0, 1'b0, 1'b0, 1'b0);
        drive(0, 0, 1'b0, 1'b0, 1'b1);        // edge T+10
        vectors++;
        if (oOverrun !== 1'b1) begin miscompares++; $display("FAIL overrun_pulse: got %b expected 1", oOverrun); end
        for (int j = 11; j <= 60; j++) begin
            @(posedge iCLK); #1;
            if (j == 11) begin
                vectors++;
                if (oOverrun !== 1'b0) begin miscompares++; $display("FAIL overrun_width: got %b expected 0", oOverrun); end
            end
            if (oFrame_En) begin
                pulses++;
                if (pulses == 1) begin at = j; cx = oFT_X; cy = oFT_Y; cdv = oDVAL; end
            end
        end
        vectors++;
        if (pulses !== 1) begin miscompares++; $display("FAIL overrun_pulse_count: got %0d expected 1", pulses); end
        vectors++;
        if (at !== 29) begin miscompares++; $display("FAIL overrun_latency: got %0d expected 29", at); end
        vectors++;
        if ({cdv, cx, cy} !== {1'b1, 10'd20, 10'd30}) begin
            miscompares++;
            $display("FAIL overrun_result: got dval=%b x=%0d y=%0d expected 1/20/30", cdv, cx, cy);
        end
        pixels(16, 5, 7, 1'b1);
        drive(0, 0, 1'b0, 1'b0, 1'b1);
        wait_result(lat);
        expect_result("after_overrun", lat, 5, 7, 1'b1);
    endtask

    task automatic test_back_to_back;
        int lat;
        pixels(16, 200, 100, 1'b1);
        drive(0, 0, 1'b0, 1'b0, 1'b1);
        pixels(16, 210, 110, 1'b1);           // accumulate next frame during divide
        for (int i = 17; i <= 60; i++) begin
            if (oFrame_En) break;
            @(posedge iCLK); #1;
        end
        vectors++;
        if ({oDVAL, oFT_X, oFT_Y} !== {1'b1, 10'd200, 10'd100}) begin
            miscompares++;
            $display("FAIL b2b_first: got dval=%b x=%0d y=%0d expected 1/200/100", oDVAL, oFT_X, oFT_Y);
        end
        drive(0, 0, 1'b0, 1'b0, 1'b1);        // first ACCUM cycle after PUBLISH
        vectors++;
        if (oOverrun !== 1'b0) begin miscompares++; $display("FAIL b2b_no_overrun: got %b expected 0", oOverrun); end
        wait_result(lat);
        expect_result("b2b_second", lat, 210, 110, 1'b1);
    endtask

    task automatic test_reset_mid_divide;
        int lat;
        int pulses;
        pulses = 0;
        pixels(16, 70, 80, 1'b1);
        drive(0, 0, 1'b0, 1'b0, 1'b1);
        repeat (11) @(posedge iCLK);
        #1;
        iRST_N = 1'b0;
        #1;
        vectors++;
        if ({oFT_X, oFT_Y, oDVAL, oFrame_En, oOverrun} !== 23'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got x=%0d y=%0d dval=%b fen=%b ovr=%b expected all 0",
                     oFT_X, oFT_Y, oDVAL, oFrame_En, oOverrun);
        end
        repeat (2) @(posedge iCLK);
        #2;
        iRST_N = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge iCLK); #1;
            if (oFrame_En) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin miscompares++; $display("FAIL midreset_no_pulse: got %0d expected 0", pulses); end
        pixels(16, 50, 60, 1'b1);
        drive(0, 0, 1'b0, 1'b0, 1'b1);
        wait_result(lat);
        expect_result("after_reset", lat, 50, 60, 1'b1);
    endtask

    initial begin
        test_reset;
        test_hand;
        test_small_frame;
        test_empty_frame;
        test_coincident;
        test_overrun;
        test_back_to_back;
        test_reset_mid_divide;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hand_centroid_tracker.md
Name: hand_centroid_tracker

Overview:
- Per-frame fingertip/hand locator that directly feeds the movement/grid-detection stage.
- Consumes the pixel-rate skin-mask stream from the colour-classification stage.
- Accumulates X/Y sums and a count of skin pixels over each frame.
- At frame end, divides the sums by the count sequentially, then presents one centroid coordinate per frame on iFT_X/iFT_Y-compatible outputs with a one-cycle frame strobe.

Parameters:
WIDTH, 640, active columns; pixels with iX >= WIDTH are ignored
HEIGHT, 480, active rows; pixels with iY >= HEIGHT are ignored
MIN_PIXELS, 16, minimum skin-pixel count for a frame to report a hand
SUM_W, 28, accumulator/dividend width; also the divider iteration count
CNT_W, 19, pixel-counter/divisor width

Ports:
iCLK  input  1  pixel clock
iRST_N  input  1  asynchronous active-low reset
iDVAL  input  1  pixel valid this cycle
iX  input  10  column of current pixel
iY  input  10  row of current pixel
iSkin  input  1  skin-mask bit of current pixel (sampled only when iDVAL=1)
iFrame_End  input  1  one-cycle pulse after the last pixel of a frame
oFT_X  output  10  centroid column, floor(sumX/count)
oFT_Y  output  10  centroid row, floor(sumY/count)
oDVAL  output  1  level: oFT_X/oFT_Y hold a valid hand position from the latest frame
oFrame_En  output  1  one-cycle pulse: new frame result published
oOverrun  output  1  one-cycle pulse: iFrame_End arrived while the divider was busy

Behaviour:
- Reset (iRST_N=0, async): all outputs 0, accumulators 0, state ACCUM.
- Accumulation (every cycle, independent of FSM state):
  - When iDVAL & iSkin & iX<WIDTH & iY<HEIGHT: sumX += iX, sumY += iY, count += 1.
  - Widths are SUM_W/CNT_W. At the defaults, overflow cannot occur for a legal frame; no saturation logic.
- Frame end, sampled at edge T, FSM in ACCUM:
  - Snapshot sumX, sumY, count into divider registers.
  - Clear the accumulators to the contribution of the current cycle's pixel only if that pixel is not part of the ending frame.
  - Rule for a pixel coincident with iFrame_End: it belongs to the ending frame and is included in the snapshot; the accumulators then clear to 0.
  - FSM goes to DIVIDE.
- FSM states:
  - ACCUM: idle; waits for iFrame_End.
  - DIVIDE: two parallel restoring dividers (sumX/count, sumY/count), 1 quotient bit per cycle MSB-first, SUM_W cycles (edges T+1..T+SUM_W).
  - PUBLISH: one cycle, edge T+SUM_W+1; then back to ACCUM.
- PUBLISH, at edge T+SUM_W+1:
  - oFrame_En=1 for exactly that one cycle.
  - If snapshot count >= MIN_PIXELS: oFT_X/oFT_Y <= quotient[9:0] and oDVAL <= 1.
  - Else: oDVAL <= 0 and oFT_X/oFT_Y hold their previous values.
  - Count==0 is handled by the same rule; divider output is ignored in that case.
- Latency: fixed SUM_W+1 cycles from the iFrame_End edge to the oFrame_En cycle (29 at the defaults), whether or not a hand is present.
- iFrame_End while in DIVIDE or PUBLISH:
  - oOverrun pulses 1 cycle.
  - The accumulators are cleared as normal, so that frame's data is discarded.
  - The in-progress division is unaffected; no second result is produced.
- Back-to-back: iFrame_End on the first ACCUM cycle after PUBLISH is accepted normally.
- oDVAL is a level that changes only in PUBLISH or on reset. The downstream stage qualifies on oFrame_En & oDVAL.
- Reset mid-DIVIDE: everything returns to the reset state, no pulse is emitted, and the next iFrame_End starts cleanly.

Test Plan:
- Reset, then 16 skin pixels at (100..115, 200), then iFrame_End at cycle T -> oFrame_En exactly at T+29; oFT_X=107 (1720/16 floored), oFT_Y=200, oDVAL=1.
- Next frame: 15 skin pixels at (300,300) -> oFrame_En pulses; oDVAL=0; oFT_X/Y stay 107/200.
- Frame of 20 pixels with iSkin=0 plus 4 pixels at iX=700 (out of range) with iSkin=1 -> count 0; oDVAL=0, no X/Y change, no hang.
- Skin pixel (639,479) coincident with iFrame_End after 15 pixels at (639,479) -> included; count=16, oFT_X=639, oFT_Y=479.
- Second iFrame_End 10 cycles after the first -> oOverrun 1-cycle pulse; only one oFrame_En; the following frame's result excludes the discarded pixels.
- Assert iRST_N=0 at T+12 during a divide -> all outputs 0 immediately; no oFrame_En; a subsequent 16-pixel frame at (50,60) yields 50/60 at latency 29.
